// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe definitions: cell encodings, line table, preference order, FSM states.
package ttt_pkg;

    localparam logic [1:0] EMPTY    = 2'b00;
    localparam logic [1:0] PLAYER   = 2'b01;
    localparam logic [1:0] COMPUTER = 2'b10;

    localparam logic [3:0] LAST_LINE = 4'd7;
    localparam logic [3:0] LAST_PREF = 4'd8;

    typedef enum logic [2:0] {
        StIdle,
        StWin,
        StBlock,
        StPref,
        StDone
    } state_t;

    // Cell index (0..8) of position 'slot' (0..2) within line 'line' (0..7).
    function automatic logic [3:0] line_cell(input logic [2:0] line, input logic [1:0] slot);
        logic [11:0] cells;
        case (line)
            3'd0:    cells = {4'd2, 4'd1, 4'd0};
            3'd1:    cells = {4'd5, 4'd4, 4'd3};
            3'd2:    cells = {4'd8, 4'd7, 4'd6};
            3'd3:    cells = {4'd6, 4'd3, 4'd0};
            3'd4:    cells = {4'd7, 4'd4, 4'd1};
            3'd5:    cells = {4'd8, 4'd5, 4'd2};
            3'd6:    cells = {4'd8, 4'd4, 4'd0};
            default: cells = {4'd6, 4'd4, 4'd2};
        endcase
        case (slot)
            2'd0:    return cells[3:0];
            2'd1:    return cells[7:4];
            default: return cells[11:8];
        endcase
    endfunction

    // Cell index tested at preference step 'step' (0..8): centre, corners, edges.
    function automatic logic [3:0] pref_cell(input logic [3:0] step);
        case (step)
            4'd0:    return 4'd4;
            4'd1:    return 4'd0;
            4'd2:    return 4'd2;
            4'd3:    return 4'd6;
            4'd4:    return 4'd8;
            4'd5:    return 4'd1;
            4'd6:    return 4'd3;
            4'd7:    return 4'd5;
            default: return 4'd7;
        endcase
    endfunction

    // Two-bit code of cell 'idx' in a packed 18-bit board.
    function automatic logic [1:0] cell_of(input logic [17:0] b, input logic [3:0] idx);
        return b[{idx, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/computer_move_generator_if.sv
// Request/result bundle between the game logic and the computer move generator.
interface computer_move_generator_if;

    logic        start;
    logic [17:0] board;
    logic        busy;
    logic        done;
    logic        move_valid;
    logic [3:0]  computer_position;
    logic        pc;

    modport master (
        output start,
        output board,
        input  busy,
        input  done,
        input  move_valid,
        input  computer_position,
        input  pc
    );

    modport slave (
        input  start,
        input  board,
        output busy,
        output done,
        output move_valid,
        output computer_position,
        output pc
    );

endinterface

// File: rtl/computer_move_generator_line_eval.sv
// Combinational check of one board line: two cells of 'side' plus one empty cell.
module line_eval
    import ttt_pkg::*;
(
    input  logic [1:0] cell0,
    input  logic [1:0] cell1,
    input  logic [1:0] cell2,
    input  logic [1:0] side,
    output logic       hit,
    output logic [1:0] empty_offset
);

    logic [1:0] n_side;
    logic [1:0] n_empty;

    // Count matching and empty cells; 11 cells match neither.
    always_comb begin
        n_side  = 2'(cell0 == side) + 2'(cell1 == side) + 2'(cell2 == side);
        n_empty = 2'(cell0 == EMPTY) + 2'(cell1 == EMPTY) + 2'(cell2 == EMPTY);
        hit     = (n_side == 2'd2) && (n_empty == 2'd1);
        if (cell0 == EMPTY) begin
            empty_offset = 2'd0;
        end else if (cell1 == EMPTY) begin
            empty_offset = 2'd1;
        end else begin
            empty_offset = 2'd2;
        end
    end

endmodule

// File: rtl/computer_move_generator.sv
// Sequential computer move selector: win, then block, then fixed preference, one step per clock.
module computer_move_generator
    import ttt_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset,
    computer_move_generator_if.slave bus
);

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [17:0] snap_q, snap_d;
    logic [3:0]  pos_q, pos_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pc_q, pc_d;

    logic [1:0]  side;
    logic        hit;
    logic [1:0]  empty_offset;
    logic [3:0]  pref_idx;

    // Select the line under test and the side being searched for.
    always_comb begin
        side     = (state_q == StBlock) ? PLAYER : COMPUTER;
        pref_idx = pref_cell(idx_q);
    end

    line_eval u_line_eval (
        .cell0        (cell_of(snap_q, line_cell(idx_q[2:0], 2'd0))),
        .cell1        (cell_of(snap_q, line_cell(idx_q[2:0], 2'd1))),
        .cell2        (cell_of(snap_q, line_cell(idx_q[2:0], 2'd2))),
        .side         (side),
        .hit          (hit),
        .empty_offset (empty_offset)
    );

    // Next-state and registered-output decisions for the search.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        pos_d   = pos_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pc_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    snap_d  = bus.board;
                    idx_d   = 4'd0;
                    busy_d  = 1'b1;
                    state_d = StWin;
                end
            end
            StWin, StBlock: begin
                if (hit) begin
                    pos_d   = line_cell(idx_q[2:0], empty_offset);
                    valid_d = 1'b1;
                    done_d  = 1'b1;
                    pc_d    = 1'b1;
                    state_d = StDone;
                end else if (idx_q == LAST_LINE) begin
                    idx_d   = 4'd0;
                    state_d = (state_q == StWin) ? StBlock : StPref;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            StPref: begin
                if (cell_of(snap_q, pref_idx) == EMPTY) begin
                    pos_d   = pref_idx;
                    valid_d = 1'b1;
                    done_d  = 1'b1;
                    pc_d    = 1'b1;
                    state_d = StDone;
                end else if (idx_q == LAST_PREF) begin
                    // No empty cell: position keeps its previous value.
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            StDone: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= StIdle;
            idx_q   <= 4'd0;
            snap_q  <= 18'd0;
            pos_q   <= 4'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            pos_q   <= pos_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pc_q    <= pc_d;
        end
    end

    assign bus.busy              = busy_q;
    assign bus.done              = done_q;
    assign bus.move_valid        = valid_q;
    assign bus.computer_position = pos_q;
    assign bus.pc                = pc_q;

endmodule

// File: tb/tb_computer_move_generator.sv
// Self-checking bench: countdown-based behavioural model, per-cycle compare, directed and random runs.
module tb_computer_move_generator;

    logic clk = 1'b0;
    logic rst = 1'b0;
    bit   checking = 1'b0;
    int   checks = 0;
    int   errors = 0;

    computer_move_generator_if bus ();

    computer_move_generator dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference search straight from the game rules: returns latency k, validity, and cell.
    function automatic void ref_search(input logic [17:0] b, output int k, output bit v,
                                       output logic [3:0] p);
        int lines[24] = '{0,1,2, 3,4,5, 6,7,8, 0,3,6, 1,4,7, 2,5,8, 0,4,8, 2,4,6};
        int prefs[9]  = '{4,0,2,6,8,1,3,5,7};
        k = 25;
        v = 1'b0;
        p = 4'd0;
        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i < 8; i++) begin
                int ns = 0;
                int ne = 0;
                int ec = 0;
                logic [1:0] sd = (ph == 0) ? 2'b10 : 2'b01;
                for (int j = 0; j < 3; j++) begin
                    logic [1:0] c = b[2*lines[3*i+j] +: 2];
                    if (c == sd) ns++;
                    if (c == 2'b00) begin
                        ne++;
                        ec = lines[3*i+j];
                    end
                end
                if (ns == 2 && ne == 1) begin
                    k = ph * 8 + i + 1;
                    v = 1'b1;
                    p = 4'(ec);
                    return;
                end
            end
        end
        for (int j = 0; j < 9; j++) begin
            if (b[2*prefs[j] +: 2] == 2'b00) begin
                k = 17 + j;
                v = 1'b1;
                p = 4'(prefs[j]);
                return;
            end
        end
    endfunction

    function automatic logic [17:0] rand_board();
        logic [17:0] b;
        for (int i = 0; i < 9; i++) begin
            int r = $urandom_range(0, 99);
            b[2*i +: 2] = (r < 40) ? 2'b00 : (r < 65) ? 2'b01 : (r < 90) ? 2'b10 : 2'b11;
        end
        return b;
    endfunction

    // Behavioural model: a busy countdown of k edges after an accepted start.
    logic       m_busy = 1'b0, m_done = 1'b0, m_pc = 1'b0, m_valid = 1'b0;
    logic [3:0] m_pos = 4'd0;
    int         m_cnt = 0;
    int         r_k;
    bit         r_v;
    logic [3:0] r_p;
    bit         r_v_hold;
    logic [3:0] r_p_hold;

    // Advance the model at each rising edge.
    always @(posedge clk) begin
        if (!rst) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_pc <= 1'b0; m_valid <= 1'b0;
            m_pos <= 4'd0; m_cnt <= 0;
        end else if (m_done) begin
            m_done <= 1'b0; m_pc <= 1'b0; m_busy <= 1'b0;
        end else if (m_busy) begin
            if (m_cnt == 1) begin
                m_done  <= 1'b1;
                m_pc    <= r_v_hold;
                m_valid <= r_v_hold;
                if (r_v_hold) m_pos <= r_p_hold;
            end
            m_cnt <= m_cnt - 1;
        end else if (bus.start) begin
            ref_search(bus.board, r_k, r_v, r_p);
            r_v_hold <= r_v;
            r_p_hold <= r_p;
            m_cnt    <= r_k;
            m_busy   <= 1'b1;
        end
    end

    // Compare every DUT output against the model away from the active edge.
    always @(negedge clk) begin
        if (checking) begin
            chk("busy", 32'(bus.busy), 32'(m_busy));
            chk("done", 32'(bus.done), 32'(m_done));
            chk("pc", 32'(bus.pc), 32'(m_pc));
            chk("move_valid", 32'(bus.move_valid), 32'(m_valid));
            chk("computer_position", 32'(bus.computer_position), 32'(m_pos));
        end
    end

    // Launch one search from an idle negedge; returns edges from start edge to done.
    task automatic do_search(input logic [17:0] b, output int lat);
        bus.board = b;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 0;
        while (!bus.done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    localparam logic [17:0] BOARD_WIN   = 18'h0000A;
    localparam logic [17:0] BOARD_BLOCK = 18'h11000;
    localparam logic [17:0] BOARD_WVB   = 18'h00225;
    localparam logic [17:0] BOARD_PREF  = 18'h00102;
    localparam logic [17:0] BOARD_FULL  = 18'b01_10_11_01_10_11_01_10_11;

    logic [17:0] dboards[5] = '{BOARD_WIN, BOARD_BLOCK, BOARD_WVB, BOARD_PREF, BOARD_FULL};
    int          dk[5]      = '{1, 11, 8, 19, 25};
    bit          dv[5]      = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [3:0]  dp[5]      = '{4'd2, 4'd7, 4'd6, 4'd2, 4'd2};

    initial begin
        int k;
        bit v;
        logic [3:0] p;
        int lat;
        int n_done;

        bus.start = 1'b0;
        bus.board = 18'd0;
        @(negedge clk);
        checking = 1'b1;
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_position", 32'(bus.computer_position), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Pin the model against hand-derived results.
        for (int i = 0; i < 5; i++) begin
            ref_search(dboards[i], k, v, p);
            chk("model_k", 32'(k), 32'(dk[i]));
            chk("model_valid", 32'(v), 32'(dv[i]));
            if (dv[i]) chk("model_pos", 32'(p), 32'(dp[i]));
        end

        // Directed searches; the full board keeps the position from the preceding search.
        for (int i = 0; i < 5; i++) begin
            do_search(dboards[i], lat);
            chk("latency", 32'(lat), 32'(dk[i]));
            chk("done_position", 32'(bus.computer_position), 32'(dp[i]));
            chk("done_valid", 32'(bus.move_valid), 32'(dv[i]));
            chk("done_pc", 32'(bus.pc), 32'(dv[i]));
            @(negedge clk);
        end

        // Reset at edge 5 of a search: outputs clear and no done follows.
        bus.board = BOARD_PREF;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midreset_busy", 32'(bus.busy), 32'd0);
        chk("midreset_position", 32'(bus.computer_position), 32'd0);
        rst = 1'b1;
        n_done = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.done) n_done++;
        end
        chk("no_done_after_reset", 32'(n_done), 32'd0);

        // Random boards, random start (including while busy), board churn, rare resets.
        repeat (1500) begin
            bus.board = rand_board();
            bus.start = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 199) != 0);
            @(negedge clk);
        end
        bus.start = 1'b0;
        rst = 1'b1;
        repeat (30) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
